// File: rtl/apb_timeout_guard_pkg.sv
// Shared types and helpers for the APB completer-side watchdog.
package apb_timeout_guard_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  // Watchdog counter width able to hold values up to timeout_cycles.
  function automatic int cnt_width(input int timeout_cycles);
    return $clog2(timeout_cycles + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_guard.sv
// APB watchdog: re-issues each upstream transfer downstream and aborts it with
// pslverr and ErrData when the peripheral fails to answer within TimeoutCycles.
module apb_timeout_guard
  import apb_timeout_guard_pkg::*;
#(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int StrbWidth     = (DataWidth + 7) / 8,
  parameter int TimeoutCycles = 16,
  parameter logic [DataWidth-1:0] ErrData = DataWidth'(32'hDEAD_BEEF)
) (
  input  logic                 pclk_i,
  input  logic                 preset_i,
  input  logic                 slv_psel_i,
  input  logic                 slv_penable_i,
  input  logic                 slv_pwrite_i,
  input  logic [AddrWidth-1:0] slv_paddr_i,
  input  logic [DataWidth-1:0] slv_pwdata_i,
  input  logic [StrbWidth-1:0] slv_pstrb_i,
  output logic                 slv_pready_o,
  output logic [DataWidth-1:0] slv_prdata_o,
  output logic                 slv_pslverr_o,
  output logic                 mst_psel_o,
  output logic                 mst_penable_o,
  output logic                 mst_pwrite_o,
  output logic [AddrWidth-1:0] mst_paddr_o,
  output logic [DataWidth-1:0] mst_pwdata_o,
  output logic [StrbWidth-1:0] mst_pstrb_o,
  input  logic                 mst_pready_i,
  input  logic [DataWidth-1:0] mst_prdata_i,
  input  logic                 mst_pslverr_i,
  output logic                 timeout_o,
  output logic [15:0]          timeout_cnt_o
);

  localparam int CntWidth = cnt_width(TimeoutCycles);
  localparam logic [CntWidth-1:0] WdLast = CntWidth'(TimeoutCycles - 1);

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    wd_cnt_q, wd_cnt_d;
  logic                   pwrite_q, pwrite_d;
  logic [AddrWidth-1:0]   paddr_q, paddr_d;
  logic [DataWidth-1:0]   pwdata_q, pwdata_d;
  logic [StrbWidth-1:0]   pstrb_q, pstrb_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic                   rerr_q, rerr_d;
  logic                   timeout_q, timeout_d;
  logic [15:0]            tcnt_q, tcnt_d;

  // Upstream penable is deliberately not checked; the guard keys only on psel.
  logic unused_penable;
  assign unused_penable = slv_penable_i;

  always_comb begin
    state_d   = state_q;
    wd_cnt_d  = wd_cnt_q;
    pwrite_d  = pwrite_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    rdata_d   = rdata_q;
    rerr_d    = rerr_q;
    timeout_d = 1'b0;
    tcnt_d    = tcnt_q;
    case (state_q)
      IDLE: begin
        if (slv_psel_i) begin
          pwrite_d = slv_pwrite_i;
          paddr_d  = slv_paddr_i;
          pwdata_d = slv_pwdata_i;
          pstrb_d  = slv_pstrb_i;
          wd_cnt_d = '0;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        wd_cnt_d = wd_cnt_q + CntWidth'(1);
        // A pready arriving on the last allowed cycle still wins over the abort.
        if (mst_pready_i) begin
          rdata_d = mst_prdata_i;
          rerr_d  = mst_pslverr_i;
          state_d = RESP;
        end else if (wd_cnt_q == WdLast) begin
          rdata_d   = ErrData;
          rerr_d    = 1'b1;
          timeout_d = 1'b1;
          tcnt_d    = (tcnt_q == 16'hFFFF) ? tcnt_q : tcnt_q + 16'd1;
          state_d   = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk_i) begin
    if (preset_i) begin
      state_q   <= IDLE;
      wd_cnt_q  <= '0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      timeout_q <= 1'b0;
      tcnt_q    <= 16'd0;
    end else begin
      state_q   <= state_d;
      wd_cnt_q  <= wd_cnt_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      rdata_q   <= rdata_d;
      rerr_q    <= rerr_d;
      timeout_q <= timeout_d;
      tcnt_q    <= tcnt_d;
    end
  end

  assign mst_psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign mst_penable_o = (state_q == ACCESS);
  assign mst_pwrite_o  = pwrite_q;
  assign mst_paddr_o   = paddr_q;
  assign mst_pwdata_o  = pwdata_q;
  assign mst_pstrb_o   = pstrb_q;
  assign slv_pready_o  = (state_q == RESP);
  assign slv_prdata_o  = (state_q == RESP) ? rdata_q : '0;
  assign slv_pslverr_o = (state_q == RESP) ? rerr_q : 1'b0;
  assign timeout_o     = timeout_q;
  assign timeout_cnt_o = tcnt_q;

endmodule
